// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised I2S frame FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DEPTH  = 1024;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Width of one multi-channel frame, channel 0 in the LSBs.
  function automatic int frame_width(input int num_ch, input int data_w);
    return num_ch * data_w;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port frame memory: synchronous write, read port either
// combinational (ASYNC_RD=1) or registered with a resettable output.
module fifo_ram import fifo_pkg::*; #(
  parameter int WIDTH    = frame_width(DEF_NUM_CH, DEF_DATA_W),
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ASYNC_RD = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd_en,
  input  logic [clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]        o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  generate
    if (ASYNC_RD) begin : g_async_rd
      logic w_unused_rd;
      assign w_unused_rd = i_rd_en ^ rst;
      assign o_rd_data   = r_mem[i_rd_addr];
    end else begin : g_sync_rd
      logic [WIDTH-1:0] r_rd_q;
      // Old contents are returned when the write targets the read address.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_rd_q <= '0;
        else if (i_rd_en) r_rd_q <= r_mem[i_rd_addr];
      end
      assign o_rd_data = r_rd_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_i2s_param.sv
// Parametrised I2S frame FIFO: level counter, full/empty, hysteretic pausa,
// sticky overflow/underflow and selectable FWFT or registered read.
module fifo_i2s_param import fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HI_THR = 768,
  parameter int LO_THR = 256,
  parameter int FWFT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [NUM_CH*DATA_W-1:0] dato_in,
  input  logic                     rd_en,
  output logic [NUM_CH*DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     empty,
  output logic                     full,
  output logic [clog2(DEPTH):0]    level,
  output logic                     pausa,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = frame_width(NUM_CH, DATA_W);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $error("fifo_i2s_param: DEPTH must be a power of two and >= 4");
    end
    if (LO_THR < 0 || LO_THR >= HI_THR || HI_THR > DEPTH) begin : g_bad_thr
      $error("fifo_i2s_param: thresholds must satisfy 0 <= LO_THR < HI_THR <= DEPTH");
    end
  endgenerate

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_pausa;
  logic          r_ovf;
  logic          r_unf;
  logic          w_empty;
  logic          w_full;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [FW-1:0] w_ram_q;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_rd_acc = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a write at full is still taken.
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
    end
  end

  // Hysteresis is judged on the level the FIFO is about to hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pausa <= 1'b0;
    end else if (w_level_nxt >= LW'(HI_THR)) begin
      r_pausa <= 1'b1;
    end else if (w_level_nxt <= LW'(LO_THR)) begin
      r_pausa <= 1'b0;
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (wr_en & ~w_wr_acc) | (r_ovf & ~clr_err);
      r_unf <= (rd_en & ~w_rd_acc) | (r_unf & ~clr_err);
    end
  end

  fifo_ram #(
    .WIDTH    (FW),
    .DEPTH    (DEPTH),
    .ASYNC_RD (FWFT != 0)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (dato_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so the head-frame output is a clean zero after reset.
      assign out       = w_empty ? '0 : w_ram_q;
      assign out_valid = ~w_empty;
    end else begin : g_reg_rd
      logic r_rd_vld;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_vld <= 1'b0;
        else      r_rd_vld <= w_rd_acc;
      end
      assign out       = w_ram_q;
      assign out_valid = r_rd_vld;
    end
  endgenerate

  assign empty     = w_empty;
  assign full      = w_full;
  assign level     = r_level;
  assign pausa     = r_pausa;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fifo_i2s_param.sv
// Directed bench for fifo_i2s_param: FWFT instance (DEPTH=8, HI=6, LO=2)
// plus a registered-read instance sharing clock and reset.
module tb_fifo_i2s_param;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, clr_err;
  logic [FW-1:0] dato_in;
  logic [FW-1:0] out;
  logic          out_valid, empty, full, pausa, overflow, underflow;
  logic [3:0]    level;

  logic          wr_en0, rd_en0, clr_err0;
  logic [FW-1:0] dato_in0;
  logic [FW-1:0] out0;
  logic          out_valid0, empty0, full0, pausa0, overflow0, underflow0;
  logic [3:0]    level0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_i2s_param #(
    .DATA_W(16), .NUM_CH(2), .DEPTH(8), .HI_THR(6), .LO_THR(2), .FWFT(1)
  ) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .dato_in(dato_in), .rd_en(rd_en),
    .out(out), .out_valid(out_valid), .empty(empty), .full(full),
    .level(level), .pausa(pausa), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  fifo_i2s_param #(
    .DATA_W(16), .NUM_CH(2), .DEPTH(8), .HI_THR(6), .LO_THR(2), .FWFT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .dato_in(dato_in0), .rd_en(rd_en0),
    .out(out0), .out_valid(out_valid0), .empty(empty0), .full(full0),
    .level(level0), .pausa(pausa0), .overflow(overflow0), .underflow(underflow0),
    .clr_err(clr_err0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; clr_err = 0;
    wr_en0 = 0; rd_en0 = 0; clr_err0 = 0;
  endtask

  // Called at posedge+1: pulse reset well clear of any clock edge.
  task automatic do_reset();
    idle();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    dato_in = '0; dato_in0 = '0;
    rst = 1'b0;
    #7;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    checks++; if (pausa !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b exp 000", pausa, overflow, underflow); end
    checks++; if (out !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%b exp 0/0", out, out_valid); end
    checks++; if (out0 !== 32'h0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out0 got %h/%b exp 0/0", out0, out_valid0); end
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1; dato_in = {16'(i), 16'(i)};
      step();
      checks++; if (level !== 4'(i)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i); end
      checks++; if (pausa !== (i >= 6)) begin errors++; $display("FAIL fill_pausa[%0d] got %b exp %b", i, pausa, (i >= 6)); end
      checks++; if (full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 8)); end
      checks++; if (out !== 32'h0001_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL fill_head[%0d] got %h/%b exp 00010001/1", i, out, out_valid); end
    end
    dato_in = 32'h0009_0009;
    step();
    checks++; if (overflow !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL fill_overflow got %b lvl %0d exp 1 lvl 8", overflow, level); end
    wr_en = 0; clr_err = 1;
    step();
    clr_err = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_clr_err got %b exp 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      checks++; if (out !== {16'(i), 16'(i)}) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, out, {16'(i), 16'(i)}); end
      rd_en = 1;
      step();
      checks++; if (level !== 4'(8 - i)) begin errors++; $display("FAIL drain_level[%0d] got %0d exp %0d", i, level, 8 - i); end
      checks++; if (pausa !== ((8 - i) > 2)) begin errors++; $display("FAIL drain_pausa[%0d] got %b exp %b", i, pausa, ((8 - i) > 2)); end
    end
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL drain_empty got e%b v%b u%b exp e1 v0 u0", empty, out_valid, underflow); end
    step();
    rd_en = 0;
    checks++; if (underflow !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL drain_underflow got %b lvl %0d exp 1 lvl 0", underflow, level); end
    clr_err = 1;
    step();
    clr_err = 0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_clr_err got %b exp 0", underflow); end
  endtask

  task automatic test_stream();
    logic [FW-1:0] q[$];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; dato_in = 32'h0100_0000 + 32'(i);
      q.push_back(dato_in);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      checks++; if (out !== q[0]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out, q[0]); end
      wr_en = 1; rd_en = 1; dato_in = 32'h0200_0000 + 32'(i * 7);
      q.push_back(dato_in);
      void'(q.pop_front());
      step();
      checks++; if (level !== 4'd3) begin errors++; $display("FAIL stream_level[%0d] got %0d exp 3", i, level); end
    end
    idle();
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || pausa !== 1'b0) begin errors++; $display("FAIL stream_flags got o%b u%b p%b exp 000", overflow, underflow, pausa); end
    checks++; if (out !== q[0]) begin errors++; $display("FAIL stream_tail got %h exp %h", out, q[0]); end
  endtask

  task automatic test_bounds();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; dato_in = 32'h0300_0000 + 32'(i);
      step();
    end
    wr_en = 1; rd_en = 1; dato_in = 32'h0300_00FF;
    step();
    idle();
    checks++; if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL bound_full got lvl %0d f%b o%b exp lvl 8 f1 o0", level, full, overflow); end
    checks++; if (out !== 32'h0300_0001) begin errors++; $display("FAIL bound_full_head got %h exp 03000001", out); end
    do_reset();
    wr_en = 1; rd_en = 1; dato_in = 32'hBEEF_CAFE;
    step();
    idle();
    checks++; if (underflow !== 1'b1 || level !== 4'd1) begin errors++; $display("FAIL bound_empty got u%b lvl %0d exp u1 lvl 1", underflow, level); end
    checks++; if (out !== 32'hBEEF_CAFE || out_valid !== 1'b1) begin errors++; $display("FAIL bound_empty_out got %h/%b exp beefcafe/1", out, out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; dato_in = 32'h0400_0000 + 32'(i);
      step();
    end
    idle();
    checks++; if (level !== 4'd5 || pausa !== 1'b0) begin errors++; $display("FAIL mid_pre got lvl %0d p%b exp lvl 5 p0", level, pausa); end
    #3 rst = 1'b0;
    #1;
    checks++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_async got lvl %0d e%b f%b exp lvl 0 e1 f0", level, empty, full); end
    checks++; if (out !== 32'h0 || out_valid !== 1'b0 || pausa !== 1'b0) begin errors++; $display("FAIL mid_async_out got %h v%b p%b exp 0 v0 p0", out, out_valid, pausa); end
    #2 rst = 1'b1;
    wr_en = 1; dato_in = 32'h1234_5678;
    step();
    wr_en = 0;
    checks++; if (out !== 32'h1234_5678 || level !== 4'd1) begin errors++; $display("FAIL mid_post got %h lvl %0d exp 12345678 lvl 1", out, level); end
    rd_en = 1;
    step();
    rd_en = 0;
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL mid_post_drain got e%b u%b exp e1 u0", empty, underflow); end
  endtask

  task automatic test_registered_read();
    do_reset();
    wr_en0 = 1; dato_in0 = 32'hAAAA_5555;
    step();
    wr_en0 = 0;
    checks++; if (out_valid0 !== 1'b0 || out0 !== 32'h0) begin errors++; $display("FAIL reg_before_read got %h/%b exp 0/0", out0, out_valid0); end
    rd_en0 = 1;
    step();
    rd_en0 = 0;
    checks++; if (out0 !== 32'hAAAA_5555 || out_valid0 !== 1'b1) begin errors++; $display("FAIL reg_read got %h/%b exp aaaa5555/1", out0, out_valid0); end
    step();
    checks++; if (out0 !== 32'hAAAA_5555 || out_valid0 !== 1'b0) begin errors++; $display("FAIL reg_hold got %h/%b exp aaaa5555/0", out0, out_valid0); end
    wr_en0 = 1; dato_in0 = 32'h1111_2222;
    step();
    dato_in0 = 32'h3333_4444;
    step();
    wr_en0 = 0; rd_en0 = 1;
    step();
    checks++; if (out0 !== 32'h1111_2222 || out_valid0 !== 1'b1) begin errors++; $display("FAIL reg_b2b_0 got %h/%b exp 11112222/1", out0, out_valid0); end
    step();
    rd_en0 = 0;
    checks++; if (out0 !== 32'h3333_4444 || out_valid0 !== 1'b1) begin errors++; $display("FAIL reg_b2b_1 got %h/%b exp 33334444/1", out0, out_valid0); end
    step();
    checks++; if (out_valid0 !== 1'b0 || empty0 !== 1'b1 || underflow0 !== 1'b0) begin errors++; $display("FAIL reg_end got v%b e%b u%b exp v0 e1 u0", out_valid0, empty0, underflow0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_bounds();
    test_reset_mid();
    test_registered_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
